cpu_stim_seq: RTL and testbench
===============================

# cpu_stim_seq

Synthesizable instruction-stimulus sequencer that replaces hand-timed `i_datain` driving of the CPU. It holds a loadable program buffer, issues the CPU `start` pulse, and feeds one instruction word per cycle with a runtime-selectable number of NOP hazard-padding slots after each word. It stops on a HALT opcode or at end of program. It sits between the bench/host loader and the CPU's `enable`/`start`/`i_datain` inputs.

## Interface
- `IW`, 16, instruction word width
- `OPW`, 5, opcode field width; the opcode is `i_datain[IW-1:IW-OPW]`
- `DEPTH`, 16, program buffer depth (power of two); `AW = $clog2(DEPTH)`
- `NOP_OP`, 5'b00000, NOP opcode
- `HALT_OP`, 5'b00001, HALT opcode
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state except buffer contents
- `load_we`  in  1  write `load_data` into the buffer at `load_addr`; ignored while `busy`
- `load_addr`  in  AW  buffer write address
- `load_data`  in  IW  instruction word
- `prog_len`  in  AW+1  number of words to issue (0..DEPTH); sampled on `run`
- `pad_n`  in  3  NOP slots issued after each non-HALT word (0..7); sampled on `run`
- `run`  in  1  start request; honoured in IDLE or DONE
- `abort`  in  1  synchronous; return to IDLE
- `cpu_enable`  out  1  CPU enable
- `cpu_start`  out  1  one-cycle CPU start pulse
- `i_datain`  out  IW  registered instruction word to the CPU
- `busy`  out  1  high in START, ISSUE, PAD and HALT_SLOT
- `done`  out  1  level, high in DONE
- `halted`  out  1  in DONE, set when termination was caused by a HALT opcode in the buffer
- `issued_cnt`  out  AW+1  number of buffer words issued since the last `run`; excludes pads and the auto-HALT word

## Operation
- States: IDLE, START, ISSUE, PAD, HALT_SLOT, DONE.
- Reset values: state=IDLE, `cpu_enable`=0, `cpu_start`=0, `i_datain`={NOP_OP,0}, `busy`=0, `done`=0, `halted`=0, `issued_cnt`=0.
- IDLE/DONE + `run`:
  - `prog_len`==0 → DONE. `cpu_start` is not pulsed; `halted`=0.
  - otherwise → START. Latch `prog_len` and `pad_n`; clear `ptr`, `issued_cnt` and `halted`.
- START: `cpu_start`=1, `cpu_enable`=1, `i_datain`=NOP. → ISSUE.
- ISSUE: `i_datain`=buf[ptr], `issued_cnt`+1.
  - opcode==HALT_OP → DONE, `halted`=1. Pads and remaining words are skipped.
  - else if pads>0 → PAD.
  - else if this was the last word → end-of-program.
  - else → ISSUE with `ptr`+1.
- PAD: `i_datain`=NOP for exactly `pad_n` cycles, then the next word or end-of-program.
- End-of-program: behaviour depends on the configuration macro (see Configuration).
- DONE: `i_datain`=NOP. `cpu_enable` stays 1 so the CPU pipeline can drain. `run` restarts.
- `cpu_enable` is sticky: cleared only by `reset` or `abort`.
- `abort` in any state → IDLE next edge with `cpu_enable`=0 and `i_datain`=NOP. `abort` has priority over `run`.
- Buffer writes are honoured only in IDLE and DONE. Writing the buffer location currently being issued is therefore impossible.
- `ptr` never wraps: `prog_len`==DEPTH issues buf[0..DEPTH-1] exactly once.

## Timing
- `run` sampled at edge k → `cpu_start`=1 during cycle k+1. This matches the CPU's start-then-fetch expectation.
- Word i is driven during cycle k+2+i·(`pad_n`+1).
- Register-to-output latency is zero; all outputs come straight from flops.
- `reset` asserted mid-program forces the reset values immediately, without waiting for a clock edge. Buffer contents survive.
- `run` and `abort` in the same cycle: `abort` wins.
- `run` while `busy`: ignored.

## Configuration
- `STIM_SEQ_AUTOHALT_EN` defined: end-of-program enters HALT_SLOT. HALT_SLOT drives `i_datain`={HALT_OP,0} for one cycle, then the sequencer enters DONE with `halted`=0.
- `STIM_SEQ_AUTOHALT_EN` undefined: end-of-program enters DONE directly with `i_datain`=NOP. HALT_SLOT does not exist.

## Test plan
- **Basic program.** buf = {16'h5010, 16'h0000, 16'h0800}, `prog_len`=3, `pad_n`=0, `run`.
  - `cpu_start` high for exactly 1 cycle.
  - Then `i_datain` = 5010, 0000, 0800.
  - `done`=1, `halted`=1, `issued_cnt`=3.
- **Padding.** buf[0]=16'h5010, buf[1]=16'h5120, `prog_len`=2, `pad_n`=3.
  - Stream is 5010, NOP×3, 5120, NOP×3.
  - Then HALT (macro on) or DONE (macro off); `issued_cnt`=2.
- **Early HALT.** buf[1]=16'h0800 with `prog_len`=8.
  - Words 2..7 are never driven; `issued_cnt`=2, `halted`=1.
- **Abort.** Assert `abort` during a PAD slot.
  - Next cycle: IDLE, `cpu_enable`=0, `i_datain`=0000.
  - A subsequent `run` restarts from buf[0].
- **Reset mid-run.** Assert `reset` during ISSUE of word 2.
  - All outputs take reset values immediately.
  - After release, `run` reissues the unchanged buffer from word 0.
- **Boundaries.**
  - `prog_len`=0 gives DONE with no `cpu_start`.
  - `prog_len`=DEPTH issues all 16 words, no wrap.
  - `load_we` while `busy` leaves the buffer unchanged.

Source files
------------

// File: rtl/cpu_stim_seq.sv
// Instruction-stimulus sequencer: loadable program buffer, CPU start pulse, per-word NOP padding.
// Define STIM_SEQ_AUTOHALT_EN to append a HALT word when the program runs out without one.
module cpu_stim_seq #(
  parameter int IW = 16,
  parameter int OPW = 5,
  parameter int DEPTH = 16,
  parameter logic [OPW-1:0] NOP_OP = 5'b00000,
  parameter logic [OPW-1:0] HALT_OP = 5'b00001,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic [AW:0]   prog_len,
  input  logic [2:0]    pad_n,
  input  logic          run,
  input  logic          abort,
  output logic          cpu_enable,
  output logic          cpu_start,
  output logic [IW-1:0] i_datain,
  output logic          busy,
  output logic          done,
  output logic          halted,
  output logic [AW:0]   issued_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ISSUE = 3'd2,
    S_PAD   = 3'd3,
`ifdef STIM_SEQ_AUTOHALT_EN
    S_HALT_SLOT = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_t;

  localparam logic [IW-1:0] NOP_WORD  = {NOP_OP, {(IW-OPW){1'b0}}};
  localparam logic [IW-1:0] HALT_WORD = {HALT_OP, {(IW-OPW){1'b0}}};
`ifdef STIM_SEQ_AUTOHALT_EN
  localparam state_t EOP_STATE = S_HALT_SLOT;
`else
  localparam state_t EOP_STATE = S_DONE;
`endif

  logic [IW-1:0] prog_mem [DEPTH];

  state_t        state_reg, state_next;
  logic [AW-1:0] ptr_reg, ptr_next;
  logic [AW:0]   len_reg, len_next;
  logic [2:0]    pad_n_reg, pad_n_next;
  logic [2:0]    pad_cnt_reg, pad_cnt_next;
  logic          halted_reg, halted_next;
  logic [AW:0]   issued_reg, issued_base, issued_next;
  logic          cpu_enable_reg, cpu_enable_next;
  logic          cpu_start_reg, cpu_start_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic [IW-1:0] i_datain_reg, i_datain_next;
  logic          last_word;
  logic          word_is_halt;

  // Loads are locked out while a program is in flight, so the issued word can never change underneath.
  always_ff @(posedge clock) begin
    if (load_we && (state_reg == S_IDLE || state_reg == S_DONE))
      prog_mem[load_addr] <= load_data;
  end

  assign last_word    = (({1'b0, ptr_reg} + (AW+1)'(1)) == len_reg);
  assign word_is_halt = (i_datain_reg[IW-1 -: OPW] == HALT_OP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    len_next     = len_reg;
    pad_n_next   = pad_n_reg;
    pad_cnt_next = pad_cnt_reg;
    halted_next  = halted_reg;
    issued_base  = issued_reg;
    if (abort) begin
      state_next  = S_IDLE;
      halted_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (run) begin
            ptr_next    = '0;
            issued_base = '0;
            halted_next = 1'b0;
            if (prog_len == '0) begin
              state_next = S_DONE;
            end else begin
              state_next = S_START;
              len_next   = prog_len;
              pad_n_next = pad_n;
            end
          end
        end
        S_START: state_next = S_ISSUE;
        S_ISSUE: begin
          if (word_is_halt) begin
            state_next  = S_DONE;
            halted_next = 1'b1;
          end else if (pad_n_reg != '0) begin
            state_next   = S_PAD;
            pad_cnt_next = pad_n_reg;
          end else if (last_word) begin
            state_next = EOP_STATE;
          end else begin
            ptr_next = ptr_reg + AW'(1);
          end
        end
        S_PAD: begin
          if (pad_cnt_reg == 3'd1) begin
            if (last_word) begin
              state_next = EOP_STATE;
            end else begin
              state_next = S_ISSUE;
              ptr_next   = ptr_reg + AW'(1);
            end
          end else begin
            pad_cnt_next = pad_cnt_reg - 3'd1;
          end
        end
`ifdef STIM_SEQ_AUTOHALT_EN
        S_HALT_SLOT: state_next = S_DONE;
`endif
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    cpu_start_next = (state_next == S_START);
    done_next      = (state_next == S_DONE);
    busy_next      = (state_next == S_START) || (state_next == S_ISSUE) || (state_next == S_PAD);
    i_datain_next  = NOP_WORD;
    issued_next    = issued_base;
    cpu_enable_next = cpu_enable_reg;
    if (abort)
      cpu_enable_next = 1'b0;
    else if (state_next == S_START)
      cpu_enable_next = 1'b1;
    if (state_next == S_ISSUE) begin
      i_datain_next = prog_mem[ptr_next];
      issued_next   = issued_base + (AW+1)'(1);
    end
`ifdef STIM_SEQ_AUTOHALT_EN
    if (state_next == S_HALT_SLOT) begin
      i_datain_next = HALT_WORD;
      busy_next     = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_reg        <= '0;
      len_reg        <= '0;
      pad_n_reg      <= '0;
      pad_cnt_reg    <= '0;
      halted_reg     <= 1'b0;
      issued_reg     <= '0;
      cpu_enable_reg <= 1'b0;
      cpu_start_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      i_datain_reg   <= NOP_WORD;
    end else begin
      ptr_reg        <= ptr_next;
      len_reg        <= len_next;
      pad_n_reg      <= pad_n_next;
      pad_cnt_reg    <= pad_cnt_next;
      halted_reg     <= halted_next;
      issued_reg     <= issued_next;
      cpu_enable_reg <= cpu_enable_next;
      cpu_start_reg  <= cpu_start_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      i_datain_reg   <= i_datain_next;
    end
  end

  assign cpu_enable = cpu_enable_reg;
  assign cpu_start  = cpu_start_reg;
  assign i_datain   = i_datain_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign halted     = halted_reg;
  assign issued_cnt = issued_reg;

endmodule

// File: tb/tb_cpu_stim_seq.sv
// Directed bench for cpu_stim_seq: expected instruction stream is queued per run and popped each cycle.
module tb_cpu_stim_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_we = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic [4:0]  prog_len = '0;
  logic [2:0]  pad_n = '0;
  logic        run = 1'b0;
  logic        abort = 1'b0;
  logic        cpu_enable, cpu_start, busy, done, halted;
  logic [15:0] i_datain;
  logic [4:0]  issued_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] model_mem [16];
  logic [15:0] exp_q [$];

  localparam logic [15:0] NOP_W  = 16'h0000;
  localparam logic [15:0] HALT_W = 16'h0800;

  cpu_stim_seq dut (
    .clock(clock), .reset(reset), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .pad_n(pad_n), .run(run),
    .abort(abort), .cpu_enable(cpu_enable), .cpu_start(cpu_start),
    .i_datain(i_datain), .busy(busy), .done(done), .halted(halted),
    .issued_cnt(issued_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".cpu_enable"}, cpu_enable, 0);
    check({tag, ".cpu_start"}, cpu_start, 0);
    check({tag, ".i_datain"}, i_datain, NOP_W);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".halted"}, halted, 0);
    check({tag, ".issued_cnt"}, issued_cnt, 0);
  endtask

  task automatic load(input int addr, input logic [15:0] data);
    load_we = 1'b1;
    load_addr = addr[3:0];
    load_data = data;
    model_mem[addr] = data;
    @(posedge clock); #1;
    load_we = 1'b0;
  endtask

  // abort_at / rst_at / wr_at name a stream index (-1 = unused)
  task automatic run_prog(input string tag, input int len, input int pad,
                          input int abort_at, input int rst_at, input int wr_at);
    logic exp_halted;
    int exp_cnt;
    int j;
    logic [15:0] e;
    exp_q = {};
    exp_halted = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(model_mem[i]);
      exp_cnt++;
      if (model_mem[i][15:11] == 5'b00001) begin
        exp_halted = 1'b1;
        break;
      end
      for (int p = 0; p < pad; p++) exp_q.push_back(NOP_W);
    end
`ifdef STIM_SEQ_AUTOHALT_EN
    if (len != 0 && !exp_halted) exp_q.push_back(HALT_W);
`endif
    $display("run %s len=%0d pad=%0d expected_stream=%0d words", tag, len, pad, exp_q.size());
    prog_len = len[4:0];
    pad_n = pad[2:0];
    run = 1'b1;
    @(posedge clock); #1;
    run = 1'b0;
    if (len == 0) begin
      check({tag, ".done"}, done, 1);
      check({tag, ".cpu_start"}, cpu_start, 0);
      check({tag, ".busy"}, busy, 0);
      check({tag, ".halted"}, halted, 0);
      check({tag, ".issued_cnt"}, issued_cnt, 0);
      return;
    end
    check({tag, ".start_pulse"}, cpu_start, 1);
    check({tag, ".start_enable"}, cpu_enable, 1);
    check({tag, ".start_data"}, i_datain, NOP_W);
    check({tag, ".start_busy"}, busy, 1);
    j = 0;
    while (exp_q.size() > 0) begin
      @(posedge clock); #1;
      load_we = (j == wr_at);
      e = exp_q.pop_front();
      check($sformatf("%s.word%0d", tag, j), i_datain, e);
      check($sformatf("%s.busy%0d", tag, j), busy, 1);
      if (j == 0) check({tag, ".start_once"}, cpu_start, 0);
      if (j == abort_at) begin
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        load_we = 1'b0;
        check({tag, ".abort_enable"}, cpu_enable, 0);
        check({tag, ".abort_data"}, i_datain, NOP_W);
        check({tag, ".abort_busy"}, busy, 0);
        check({tag, ".abort_done"}, done, 0);
        return;
      end
      if (j == rst_at) begin
        reset = 1'b1;
        #1;
        check_reset_vals({tag, ".async_rst"});
        @(posedge clock); #1;
        reset = 1'b0;
        load_we = 1'b0;
        return;
      end
      j++;
    end
    load_we = 1'b0;
    @(posedge clock); #1;
    check({tag, ".done"}, done, 1);
    check({tag, ".end_busy"}, busy, 0);
    check({tag, ".end_data"}, i_datain, NOP_W);
    check({tag, ".end_enable"}, cpu_enable, 1);
    check({tag, ".halted"}, halted, exp_halted);
    check({tag, ".issued_cnt"}, issued_cnt, exp_cnt);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
    repeat (2) @(posedge clock);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    @(posedge clock); #1;
    check_reset_vals("idle");

    load(0, 16'h5010);
    load(1, 16'h0000);
    load(2, 16'h0800);
    run_prog("basic", 3, 0, -1, -1, -1);

    run = 1'b1;
    abort = 1'b1;
    @(posedge clock); #1;
    run = 1'b0;
    abort = 1'b0;
    check("run_abort.busy", busy, 0);
    check("run_abort.cpu_start", cpu_start, 0);
    check("run_abort.done", done, 0);
    check("run_abort.enable", cpu_enable, 0);

    load(1, 16'h5120);
    run_prog("padding", 2, 3, -1, -1, -1);

    load(1, 16'h0800);
    run_prog("early_halt", 8, 0, -1, -1, -1);
    run_prog("len_zero", 0, 0, -1, -1, -1);

    load(1, 16'h5120);
    run_prog("abort_pad", 2, 3, 2, -1, -1);
    run_prog("after_abort", 2, 3, -1, -1, -1);

    run_prog("reset_mid", 3, 0, -1, 2, -1);
    run_prog("after_reset", 3, 0, -1, -1, -1);

    load_addr = 4'd0;
    load_data = 16'h7777;
    run_prog("load_busy", 2, 3, -1, -1, 1);
    run_prog("load_busy_chk", 2, 0, -1, -1, -1);

    for (int i = 0; i < 16; i++) load(i, 16'h3000 + 16'(i));
    run_prog("full_depth", 16, 0, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
